seg_scan_arbiter: RTL and testbench
===================================

Name: seg_scan_arbiter

Overview:
- Drives the shared 8-digit multiplexed 7-segment display (DIG/Y) for the game.
- Arbitrates between two sources:
  - Base source: the game's live score/timer digits, shown by default.
  - Message source: a one-shot request, such as a win/lose code, that pre-empts the base for a programmable number of scan frames.
- Sits between gameControl-side logic and the board DIG/Y pins, clocked by the divided system clock.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays selected (must be ≥2).
- HOLD_FRAMES, 200: full scan frames a message is held before reverting to base (must be ≥1).

Ports:
- clk  input  1: divided system clock.
- rst  input  1: asynchronous, active-low reset.
- base_data  input  32: 8 hex nibbles for base display; nibble i ([4i+3:4i]) maps to digit i.
- base_blank  input  8: bit i=1 blanks base digit i.
- base_dp  input  8: decimal point per base digit.
- msg_req  input  1: message request, level or pulse, sampled every cycle.
- msg_data  input  32: message nibbles, same layout as base_data.
- msg_dp  input  8: message decimal points.
- msg_ack  output  1: one-cycle pulse when a request is accepted.
- msg_busy  output  1: high while the message is displayed.
- DIG  output  8: digit select, active-low, one-hot-zero; DIG[0] is the rightmost digit.
- Y  output  8: segments, active-high; Y[6:0]=g..a, Y[7]=dp.

Behaviour:
- Reset (rst=0, async) sets:
  - Outputs: DIG=8'hFF, Y=8'h00, msg_ack=0, msg_busy=0.
  - Internal state: scan counter=0, digit index=0, FSM=BASE, hold counter=0, message latches=0.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On wrap, digit index increments mod 8 (7→0).
  - frame_tick is an internal one-cycle strobe, asserted on the wrap cycle when index=7.
- Output register, one cycle of latency from the index:
  - DIG <= ~(1<<idx).
  - Y <= {dp, hexseg(nibble)} of the selected source.
  - Sources are sampled live each cycle: base_* in BASE, latched message in MSG.
- Base blanking: in BASE, if base_blank[idx]=1 then DIG <= 8'hFF and Y <= 8'h00 for that slot. The message source has no blanking.
- hexseg encoding:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- FSM states:
  - BASE: displays base_*. If msg_req=1:
    - Latch msg_data and msg_dp.
    - Load hold=HOLD_FRAMES.
    - Pulse msg_ack for one cycle.
    - Go to MSG.
  - MSG: displays the latched message; msg_busy=1.
    - On frame_tick, hold decrements.
    - If frame_tick and hold==1, go to BASE.
    - msg_req=1 in MSG: re-latch the data, reload hold=HOLD_FRAMES, pulse msg_ack, stay in MSG. This takes priority over expiry in the same cycle.
- Level-held msg_req re-acks every cycle and keeps reloading, so a message held high stays up indefinitely. Requesters must pulse for a timed display.
- Message timing: the partial frame in progress at acceptance counts as frame 1. Display time is between (HOLD_FRAMES-1) and HOLD_FRAMES frames.
- Scan position is unaffected by state changes; the scan never resets except on rst.
- msg_busy is registered and changes in the same cycle as the FSM state.
- Acceptance and the switch of the displayed source:
  - msg_ack is high in the cycle after msg_req is sampled.
  - The new source appears on Y in the cycle after that.

Test Plan:
Parameters for the bench: SCAN_DIV=4, HOLD_FRAMES=2 (frame = 32 cycles).
1. Reset and scan, with base_data=32'h76543210, blank=0, dp=0.
   - During reset: DIG=FF, Y=00.
   - After release: DIG walks FE,FD,…,7F, each value held 4 cycles.
   - Y follows 3F,06,5B,4F,66,6D,7D,07.
   - Wraps to FE after 32 cycles.
2. Blank/dp: base_blank=8'h80, base_dp=8'h01.
   - Digit 0 shows Y=BF.
   - Digit 7 slot shows DIG=FF, Y=00.
3. Message accept: one-cycle msg_req with msg_data=32'hEEEEEEEE mid-frame.
   - msg_ack pulses once.
   - msg_busy=1.
   - Y=79 on subsequent digits.
   - Reverts to base on the 2nd frame_tick; msg_busy drops that cycle.
4. Retrigger: second pulse with msg_data=32'hAAAAAAAA during MSG, in the same cycle as the expiring frame_tick.
   - State stays MSG.
   - Y=77 for up to 2 more frames.
   - msg_ack pulses.
5. Held request: msg_req held high for 100 cycles.
   - msg_ack is high every one of those cycles; msg_busy stays 1.
   - Expiry occurs 1–2 frames after release.
6. Reset mid-message: assert rst asynchronously during MSG.
   - DIG=FF, Y=00, msg_busy=0 immediately, with no clock edge.
   - After release: base display resumes from digit 0.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// 8-digit multiplexed 7-segment scanner arbitrating between live base
// digits and a one-shot message held for a number of scan frames.
module seg_scan_arbiter #(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_FRAMES = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] base_data,
   input  logic [7:0]  base_blank,
   input  logic [7:0]  base_dp,
   input  logic        msg_req,
   input  logic [31:0] msg_data,
   input  logic [7:0]  msg_dp,
   output logic        msg_ack,
   output logic        msg_busy,
   output logic [7:0]  DIG,
   output logic [7:0]  Y
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int HW = $clog2(HOLD_FRAMES + 1);

   typedef enum logic {S_BASE, S_MSG} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_scan_cnt;
   logic [2:0]      r_idx;
   logic [HW-1:0]   r_hold;
   logic [HW-1:0]   w_hold_next;
   logic [31:0]     r_msg_data;
   logic [7:0]      r_msg_dp;
   logic            r_ack;
   logic            r_busy;
   logic [7:0]      r_dig;
   logic [7:0]      r_y;
   logic            w_wrap;
   logic            w_frame_tick;
   logic            w_accept;
   logic [3:0]      w_nib;
   logic            w_dp;
   logic            w_blank;

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign w_wrap       = (r_scan_cnt == CW'(SCAN_DIV - 1));
   assign w_frame_tick = w_wrap && (r_idx == 3'd7);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else if (w_wrap) begin
         r_scan_cnt <= '0;
         r_idx      <= r_idx + 3'd1;
      end else begin
         r_scan_cnt <= r_scan_cnt + CW'(1);
      end
   end

   // A new request always wins over expiry so retriggers never drop out.
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_hold_next = r_hold;
      unique case (r_state)
         S_BASE: begin
            if (msg_req) begin
               w_accept    = 1'b1;
               w_hold_next = HW'(HOLD_FRAMES);
               w_next      = S_MSG;
            end
         end
         S_MSG: begin
            if (msg_req) begin
               w_accept    = 1'b1;
               w_hold_next = HW'(HOLD_FRAMES);
            end else if (w_frame_tick) begin
               if (r_hold == HW'(1)) begin
                  w_hold_next = '0;
                  w_next      = S_BASE;
               end else begin
                  w_hold_next = r_hold - HW'(1);
               end
            end
         end
         default: w_next = S_BASE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_BASE;
         r_hold     <= '0;
         r_msg_data <= '0;
         r_msg_dp   <= '0;
         r_ack      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_hold  <= w_hold_next;
         r_ack   <= w_accept;
         r_busy  <= (w_next == S_MSG);
         if (w_accept) begin
            r_msg_data <= msg_data;
            r_msg_dp   <= msg_dp;
         end
      end
   end

   always_comb begin
      w_nib   = base_data[{r_idx, 2'b00} +: 4];
      w_dp    = base_dp[r_idx];
      w_blank = base_blank[r_idx];
      if (r_state == S_MSG) begin
         w_nib   = r_msg_data[{r_idx, 2'b00} +: 4];
         w_dp    = r_msg_dp[r_idx];
         w_blank = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dig <= 8'hFF;
         r_y   <= 8'h00;
      end else if (w_blank) begin
         r_dig <= 8'hFF;
         r_y   <= 8'h00;
      end else begin
         r_dig <= ~(8'h01 << r_idx);
         r_y   <= {w_dp, hexseg(w_nib)};
      end
   end

   assign msg_ack  = r_ack;
   assign msg_busy = r_busy;
   assign DIG      = r_dig;
   assign Y        = r_y;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with SCAN_DIV=4, HOLD_FRAMES=2.
module tb_seg_scan_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] base_data;
   logic [7:0]  base_blank;
   logic [7:0]  base_dp;
   logic        msg_req;
   logic [31:0] msg_data;
   logic [7:0]  msg_dp;
   logic        msg_ack;
   logic        msg_busy;
   logic [7:0]  DIG;
   logic [7:0]  Y;

   int n_chk  = 0;
   int n_fail = 0;
   int n      = 0;

   logic [6:0] seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                            7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C,
                            7'h39, 7'h5E, 7'h79, 7'h71};

   seg_scan_arbiter #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
      .clk(clk), .rst(rst),
      .base_data(base_data), .base_blank(base_blank), .base_dp(base_dp),
      .msg_req(msg_req), .msg_data(msg_data), .msg_dp(msg_dp),
      .msg_ack(msg_ack), .msg_busy(msg_busy), .DIG(DIG), .Y(Y)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   function automatic int cur_digit();
      return ((n - 1) / 4) % 8;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      base_data = 32'h76543210; base_blank = 8'h00; base_dp = 8'h00;
      msg_req = 1'b0; msg_data = '0; msg_dp = '0;
      repeat (3) step();
      n_chk++;
      if (DIG !== 8'hFF || Y !== 8'h00 || msg_ack !== 1'b0 || msg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: DIG=%h Y=%h ack=%b busy=%b want FF 00 0 0",
                  DIG, Y, msg_ack, msg_busy);
      end
      rst = 1'b1;
      n = 0;
   endtask

   task automatic test_scan();
      for (int k = 0; k < 33; k++) begin
         int d;
         step();
         d = cur_digit();
         n_chk++;
         if (DIG !== ~(8'h01 << d) || Y !== {1'b0, seg[d]}) begin
            n_fail++;
            $display("FAIL scan edge %0d: DIG=%h Y=%h want %h %h",
                     n, DIG, Y, ~(8'h01 << d), {1'b0, seg[d]});
         end
      end
   endtask

   task automatic test_blank_dp();
      base_blank = 8'h80; base_dp = 8'h01;
      for (int k = 0; k < 32; k++) begin
         int d;
         logic [7:0] ed, ey;
         step();
         d  = cur_digit();
         ed = (d == 7) ? 8'hFF : ~(8'h01 << d);
         ey = (d == 7) ? 8'h00 : {(d == 0), seg[d]};
         n_chk++;
         if (DIG !== ed || Y !== ey) begin
            n_fail++;
            $display("FAIL blank_dp edge %0d: DIG=%h Y=%h want %h %h",
                     n, DIG, Y, ed, ey);
         end
      end
      base_blank = 8'h00; base_dp = 8'h00;
   endtask

   task automatic test_msg_accept();
      int a, e, acks, d;
      while (n % 32 != 9) step();
      msg_req = 1'b1; msg_data = 32'hEEEEEEEE; msg_dp = 8'h00;
      step();
      a = n;
      msg_req = 1'b0;
      n_chk++;
      if (msg_ack !== 1'b1 || msg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL accept: ack=%b busy=%b want 1 1", msg_ack, msg_busy);
      end
      acks = 1; e = -1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (msg_ack === 1'b1) acks++;
         if (msg_busy !== 1'b1) begin
            e = n;
            break;
         end
         n_chk++;
         if (Y !== 8'h79) begin
            n_fail++;
            $display("FAIL msg_y edge %0d: Y=%h want 79", n, Y);
         end
      end
      n_chk++;
      if (e !== a - 10 + 64) begin
         n_fail++;
         $display("FAIL msg_expiry: edge=%0d want %0d", e, a - 10 + 64);
      end
      n_chk++;
      if (acks !== 1) begin
         n_fail++;
         $display("FAIL ack_count: got %0d want 1", acks);
      end
      step();
      d = cur_digit();
      n_chk++;
      if (Y !== {1'b0, seg[d]} || DIG !== ~(8'h01 << d)) begin
         n_fail++;
         $display("FAIL revert: DIG=%h Y=%h want %h %h",
                  DIG, Y, ~(8'h01 << d), {1'b0, seg[d]});
      end
   endtask

   task automatic test_retrigger();
      int x, e;
      while (n % 32 != 4) step();
      msg_req = 1'b1; msg_data = 32'hEEEEEEEE;
      step();
      msg_req = 1'b0;
      x = (n / 32 + 2) * 32;
      while (n < x - 1) step();
      n_chk++;
      if (msg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_retrig busy: got %b want 1", msg_busy);
      end
      msg_req = 1'b1; msg_data = 32'hAAAAAAAA;
      step();
      msg_req = 1'b0;
      n_chk++;
      if (msg_ack !== 1'b1 || msg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL retrig: ack=%b busy=%b want 1 1", msg_ack, msg_busy);
      end
      e = -1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (msg_busy !== 1'b1) begin
            e = n;
            break;
         end
         n_chk++;
         if (Y !== 8'h77 || msg_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig_y edge %0d: Y=%h ack=%b want 77 0", n, Y, msg_ack);
         end
      end
      n_chk++;
      if (e !== x + 64) begin
         n_fail++;
         $display("FAIL retrig_expiry: edge=%0d want %0d", e, x + 64);
      end
   endtask

   task automatic test_held_req();
      int r, e;
      step();
      msg_req = 1'b1; msg_data = 32'h00000000; msg_dp = 8'hFF;
      for (int k = 0; k < 100; k++) begin
         step();
         n_chk++;
         if (msg_ack !== 1'b1 || msg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held k=%0d: ack=%b busy=%b want 1 1", k, msg_ack, msg_busy);
         end
         if (k >= 1) begin
            n_chk++;
            if (Y !== 8'hBF) begin
               n_fail++;
               $display("FAIL held_y k=%0d: Y=%h want BF", k, Y);
            end
         end
      end
      r = n;
      msg_req = 1'b0;
      e = -1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (msg_busy !== 1'b1) begin
            e = n;
            break;
         end
      end
      n_chk++;
      if (e !== (r / 32 + 2) * 32) begin
         n_fail++;
         $display("FAIL held_expiry: edge=%0d want %0d", e, (r / 32 + 2) * 32);
      end
   endtask

   task automatic test_reset_mid_msg();
      msg_req = 1'b1; msg_data = 32'hAAAAAAAA; msg_dp = 8'h00;
      step();
      msg_req = 1'b0;
      repeat (5) step();
      n_chk++;
      if (msg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset busy: got %b want 1", msg_busy);
      end
      #2;
      rst = 1'b0;
      #1;
      n_chk++;
      if (DIG !== 8'hFF || Y !== 8'h00 || msg_busy !== 1'b0 || msg_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: DIG=%h Y=%h busy=%b ack=%b want FF 00 0 0",
                  DIG, Y, msg_busy, msg_ack);
      end
      repeat (2) step();
      rst = 1'b1;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         int d;
         step();
         d = cur_digit();
         n_chk++;
         if (DIG !== ~(8'h01 << d) || Y !== {1'b0, seg[d]} || msg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset edge %0d: DIG=%h Y=%h busy=%b want %h %h 0",
                     n, DIG, Y, msg_busy, ~(8'h01 << d), {1'b0, seg[d]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_blank_dp();
      test_msg_accept();
      test_retrigger();
      test_held_req();
      test_reset_mid_msg();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
